// File: rtl/rram_controller_if.sv
// rtl/rram_controller_if.sv - simplified Wishbone register/IM port bundle for rram_controller
//
// Purpose : groups the software-facing bus of the crossbar sequencer.
// Signals : wishbone_data_in     write data (master -> slave)
//           wishbone_address_bus byte address (master -> slave)
//           wbs_we_i             write strobe, one write per high cycle (master -> slave)
//           wishbone_data_out    registered read data (slave -> master)
interface rram_controller_if #(
  parameter int IF_SIZE = 32
);
  logic [IF_SIZE-1:0] wishbone_data_in;
  logic [IF_SIZE-1:0] wishbone_data_out;
  logic [IF_SIZE-1:0] wishbone_address_bus;
  logic               wbs_we_i;

  modport master (
    output wishbone_data_in,
    output wishbone_address_bus,
    output wbs_we_i,
    input  wishbone_data_out
  );

  modport slave (
    input  wishbone_data_in,
    input  wishbone_address_bus,
    input  wbs_we_i,
    output wishbone_data_out
  );
endinterface

// File: rtl/rram_controller.sv
// rtl/rram_controller.sv - instruction sequencer for a 16x16 1T1R RRAM crossbar
//
// Purpose : software fills a 128-word instruction memory over the bus, then
//           enable_IM runs it from PC 0. Each instruction (NOP/SET/RESET/READ/
//           MAC/HALT) drives registered array enables and line selects, and
//           READ/MAC capture sense-amp / ADC results into bus-readable registers.
// Ports   : clk, rst (async, active low)
//           wb          bus slave (IM 0x000-0x1FC, READ 0x200, ADC0-2 0x204-0x20C,
//                       status 0x210, perf counter 0x214)
//           enable_IM   run (1) / stop and allow IM writes (0)
//           CSA, ADC_OUT0..2          sense inputs
//           ENABLE_WL/BL/SL, ENABLE_CSA, SAEN_CSA, PRE, ENABLE_ADC, CLK_EN_ADC
//           IN0_WL/BL/SL, IN1_WL/BL/SL  line selects
// Option  : define RRAM_PERF_CNT_EN to add the executed-instruction counter at 0x214.
module rram_controller #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int ARRAY_SIZE       = 16,
  parameter int IF_SIZE          = 32,
  parameter int ADDR_SIZE_IM     = 7,
  parameter int WRITE_CYCLES     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rram_controller_if.slave      wb,
  input  logic                  enable_IM,
  input  logic [ARRAY_SIZE-1:0] CSA,
  input  logic [ARRAY_SIZE-1:0] ADC_OUT0,
  input  logic [ARRAY_SIZE-1:0] ADC_OUT1,
  input  logic [ARRAY_SIZE-1:0] ADC_OUT2,
  output logic                  ENABLE_WL,
  output logic                  ENABLE_BL,
  output logic                  ENABLE_SL,
  output logic                  ENABLE_CSA,
  output logic                  SAEN_CSA,
  output logic                  PRE,
  output logic                  ENABLE_ADC,
  output logic [1:0]            CLK_EN_ADC,
  output logic [ARRAY_SIZE-1:0] IN0_WL,
  output logic [ARRAY_SIZE-1:0] IN0_BL,
  output logic [ARRAY_SIZE-1:0] IN0_SL,
  output logic [ARRAY_SIZE-1:0] IN1_WL,
  output logic [ARRAY_SIZE-1:0] IN1_BL,
  output logic [ARRAY_SIZE-1:0] IN1_SL
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SET   = 3'b001;
  localparam logic [2:0] OP_RESET = 3'b010;
  localparam logic [2:0] OP_READ  = 3'b011;
  localparam logic [2:0] OP_MAC   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam int IM_DEPTH = 1 << ADDR_SIZE_IM;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  typedef struct packed {
    logic                  en_wl;
    logic                  en_bl;
    logic                  en_sl;
    logic                  en_csa;
    logic                  saen;
    logic                  pre;
    logic                  en_adc;
    logic [1:0]            clk_en;
    logic [ARRAY_SIZE-1:0] in0_wl;
    logic [ARRAY_SIZE-1:0] in0_bl;
    logic [ARRAY_SIZE-1:0] in0_sl;
    logic [ARRAY_SIZE-1:0] in1_wl;
    logic [ARRAY_SIZE-1:0] in1_bl;
    logic [ARRAY_SIZE-1:0] in1_sl;
  } drv_t;

  logic [INSTRUCTION_SIZE-1:0] im_q [IM_DEPTH];

  state_t                   state_q;
  logic [ADDR_SIZE_IM-1:0]  pc_q;
  logic [INSTRUCTION_SIZE-1:0] instr_q;
  logic [3:0]               cyc_q;
  drv_t                     drv_q;
  drv_t                     drv_d;
  logic [IF_SIZE-1:0]       read_q;
  logic [IF_SIZE-1:0]       adc0_q;
  logic [IF_SIZE-1:0]       adc1_q;
  logic [IF_SIZE-1:0]       adc2_q;
  logic [IF_SIZE-1:0]       rdata_q;
  logic [IF_SIZE-1:0]       rdata_d;
  logic [IF_SIZE-1:0]       perf_rd;

  logic [INSTRUCTION_SIZE-1:0] cur_instr;
  logic [3:0]               next_cyc;
  logic [2:0]               opcode;
  logic [3:0]               row;
  logic [3:0]               col;
  logic [ARRAY_SIZE-1:0]    row_oh;
  logic [ARRAY_SIZE-1:0]    col_oh;
  logic                     exec_last;
  logic                     im_hit;
  logic [9:0]               word_addr;

  function automatic logic [3:0] last_cyc(input logic [2:0] op);
    case (op)
      OP_SET, OP_RESET: return 4'(WRITE_CYCLES - 1);
      OP_READ, OP_MAC:  return 4'd2;
      default:          return 4'd0;
    endcase
  endfunction

  // During FETCH the drive pattern for the first EXEC cycle is built straight
  // from the IM word so that it is registered on the FETCH->EXEC edge.
  always_comb begin
    cur_instr = (state_q == S_FETCH) ? im_q[pc_q] : instr_q;
    next_cyc  = (state_q == S_FETCH) ? 4'd0 : cyc_q + 4'd1;
    opcode    = cur_instr[31:29];
    row       = cur_instr[27:24];
    col       = cur_instr[23:20];
    row_oh    = ARRAY_SIZE'(1) << row;
    col_oh    = ARRAY_SIZE'(1) << col;
    exec_last = (state_q == S_EXEC) && (cyc_q == last_cyc(instr_q[31:29]));

    drv_d = '0;
    case (opcode)
      OP_SET: begin
        drv_d.en_wl  = 1'b1;
        drv_d.en_bl  = 1'b1;
        drv_d.en_sl  = 1'b1;
        drv_d.in1_wl = row_oh;
        drv_d.in1_bl = col_oh;
        drv_d.in0_sl = col_oh;
      end
      OP_RESET: begin
        drv_d.en_wl  = 1'b1;
        drv_d.en_bl  = 1'b1;
        drv_d.en_sl  = 1'b1;
        drv_d.in1_wl = row_oh;
        drv_d.in1_sl = col_oh;
        drv_d.in0_bl = col_oh;
      end
      OP_READ: begin
        drv_d.en_wl  = 1'b1;
        drv_d.in1_wl = row_oh;
        drv_d.pre    = (next_cyc == 4'd0);
        drv_d.en_csa = (next_cyc == 4'd1);
        drv_d.saen   = (next_cyc == 4'd1);
      end
      OP_MAC: begin
        drv_d.en_wl  = 1'b1;
        drv_d.en_adc = 1'b1;
        drv_d.in1_wl = cur_instr[ARRAY_SIZE-1:0];
        drv_d.clk_en = (next_cyc == 4'd0) ? 2'b01 :
                       (next_cyc == 4'd1) ? 2'b10 : 2'b00;
      end
      default: drv_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cyc_q   <= '0;
      drv_q   <= '0;
      read_q  <= '0;
      adc0_q  <= '0;
      adc1_q  <= '0;
      adc2_q  <= '0;
    end else if (!enable_IM) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cyc_q   <= '0;
      drv_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          drv_q   <= '0;
        end
        S_FETCH: begin
          instr_q <= im_q[pc_q];
          cyc_q   <= '0;
          drv_q   <= drv_d;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_last) begin
            // Drivers drop for the following FETCH cycle so that consecutive
            // instructions never overlap on the array.
            drv_q <= '0;
            if (opcode == OP_READ) begin
              read_q <= {CSA, {(IF_SIZE-ARRAY_SIZE-1){1'b0}}, CSA[col]};
            end
            if (opcode == OP_MAC) begin
              adc0_q <= IF_SIZE'(ADC_OUT0);
              adc1_q <= IF_SIZE'(ADC_OUT1);
              adc2_q <= IF_SIZE'(ADC_OUT2);
            end
            if (opcode == OP_HALT || (&pc_q)) begin
              state_q <= S_DONE;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
          end else begin
            cyc_q <= next_cyc;
            drv_q <= drv_d;
          end
        end
        S_DONE: begin
          drv_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign word_addr = wb.wishbone_address_bus[11:2];
  assign im_hit    = (wb.wishbone_address_bus[11:ADDR_SIZE_IM+2] == '0);

  // IM content survives reset; bus writes land only while the program is stopped.
  always_ff @(posedge clk) begin
    if (wb.wbs_we_i && !enable_IM && im_hit) begin
      im_q[wb.wishbone_address_bus[ADDR_SIZE_IM+1:2]] <= wb.wishbone_data_in;
    end
  end

`ifdef RRAM_PERF_CNT_EN
  logic [IF_SIZE-1:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (wb.wbs_we_i && word_addr == 10'h085) begin
      perf_q <= '0;
    end else if (exec_last && enable_IM && instr_q[31:29] inside {OP_SET, OP_RESET, OP_READ, OP_MAC, OP_HALT}
                 && !(&perf_q)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_rd = perf_q;
`else
  assign perf_rd = '0;
`endif

  always_comb begin
    rdata_d = '0;
    if (im_hit) begin
      rdata_d = im_q[wb.wishbone_address_bus[ADDR_SIZE_IM+1:2]];
    end else begin
      case (word_addr)
        10'h080: rdata_d = read_q;
        10'h081: rdata_d = adc0_q;
        10'h082: rdata_d = adc1_q;
        10'h083: rdata_d = adc2_q;
        10'h084: rdata_d = IF_SIZE'({(state_q == S_DONE),
                                     (state_q == S_FETCH || state_q == S_EXEC),
                                     pc_q});
        10'h085: rdata_d = perf_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign wb.wishbone_data_out = rdata_q;

  assign ENABLE_WL  = drv_q.en_wl;
  assign ENABLE_BL  = drv_q.en_bl;
  assign ENABLE_SL  = drv_q.en_sl;
  assign ENABLE_CSA = drv_q.en_csa;
  assign SAEN_CSA   = drv_q.saen;
  assign PRE        = drv_q.pre;
  assign ENABLE_ADC = drv_q.en_adc;
  assign CLK_EN_ADC = drv_q.clk_en;
  assign IN0_WL     = drv_q.in0_wl;
  assign IN0_BL     = drv_q.in0_bl;
  assign IN0_SL     = drv_q.in0_sl;
  assign IN1_WL     = drv_q.in1_wl;
  assign IN1_BL     = drv_q.in1_bl;
  assign IN1_SL     = drv_q.in1_sl;

  logic unused_bits;
  assign unused_bits = &{1'b0, wb.wishbone_address_bus[IF_SIZE-1:12],
                         wb.wishbone_address_bus[1:0], cur_instr[28], cur_instr[19:16]};

endmodule

// File: tb/tb_rram_controller.sv
// tb/tb_rram_controller.sv - scoreboard bench for rram_controller
module tb_rram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_IM = 1'b0;
  logic [15:0] CSA = '0;
  logic [15:0] ADC_OUT0 = '0;
  logic [15:0] ADC_OUT1 = '0;
  logic [15:0] ADC_OUT2 = '0;
  logic        ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, SAEN_CSA, PRE, ENABLE_ADC;
  logic [1:0]  CLK_EN_ADC;
  logic [15:0] IN0_WL, IN0_BL, IN0_SL, IN1_WL, IN1_BL, IN1_SL;

  rram_controller_if wb_if ();

  rram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb_if.slave),
    .enable_IM  (enable_IM),
    .CSA        (CSA),
    .ADC_OUT0   (ADC_OUT0),
    .ADC_OUT1   (ADC_OUT1),
    .ADC_OUT2   (ADC_OUT2),
    .ENABLE_WL  (ENABLE_WL),
    .ENABLE_BL  (ENABLE_BL),
    .ENABLE_SL  (ENABLE_SL),
    .ENABLE_CSA (ENABLE_CSA),
    .SAEN_CSA   (SAEN_CSA),
    .PRE        (PRE),
    .ENABLE_ADC (ENABLE_ADC),
    .CLK_EN_ADC (CLK_EN_ADC),
    .IN0_WL     (IN0_WL),
    .IN0_BL     (IN0_BL),
    .IN0_SL     (IN0_SL),
    .IN1_WL     (IN1_WL),
    .IN1_BL     (IN1_BL),
    .IN1_SL     (IN1_SL)
  );

  always #5 clk = ~clk;

  logic [104:0] drv_vec;
  assign drv_vec = {ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, SAEN_CSA, PRE, ENABLE_ADC,
                    CLK_EN_ADC, IN0_WL, IN0_BL, IN0_SL, IN1_WL, IN1_BL, IN1_SL};

  logic [104:0] exp_drv_q [$];
  logic [31:0]  exp_rd_q [$];
  string        rd_name_q [$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic         rd_req = 1'b0;
  logic         rd_req_d = 1'b0;

  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor: every cycle with any drive activity consumes one expected cycle;
  // every completed bus read consumes one expected read value.
  always @(negedge clk) begin
    logic [104:0] e;
    logic [31:0]  r;
    string        nm;
    if (drv_vec !== '0) begin
      n_checks++;
      if (exp_drv_q.size() == 0) begin
        n_fail++;
        $display("FAIL drive_unexpected: got %h required no drive activity", drv_vec);
      end else begin
        e = exp_drv_q.pop_front();
        if (drv_vec !== e) begin
          n_fail++;
          $display("FAIL drive_cycle: got %h required %h", drv_vec, e);
        end
      end
    end
    if (rd_req_d) begin
      n_checks++;
      if (exp_rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_unexpected: got %h with no expected value", wb_if.wishbone_data_out);
      end else begin
        r  = exp_rd_q.pop_front();
        nm = rd_name_q.pop_front();
        if (wb_if.wishbone_data_out !== r) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", nm, wb_if.wishbone_data_out, r);
        end
      end
    end
  end

  task automatic exp_cyc(input logic wl, bl, sl, csa, saen, pre, adc, input logic [1:0] ck,
                         input logic [15:0] i0wl, i0bl, i0sl, i1wl, i1bl, i1sl);
    exp_drv_q.push_back({wl, bl, sl, csa, saen, pre, adc, ck, i0wl, i0bl, i0sl, i1wl, i1bl, i1sl});
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_if.wishbone_address_bus = a;
    wb_if.wishbone_data_in     = d;
    wb_if.wbs_we_i             = 1'b1;
    @(negedge clk);
    wb_if.wbs_we_i             = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    wb_if.wishbone_address_bus = a;
    wb_if.wbs_we_i             = 1'b0;
    exp_rd_q.push_back(e);
    rd_name_q.push_back(nm);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic run_to_done();
    @(negedge clk);
    enable_IM = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_if.wishbone_data_in     = '0;
    wb_if.wishbone_address_bus = '0;
    wb_if.wbs_we_i             = 1'b0;

    // 1: reset
    #10;
    n_checks++;
    if (drv_vec !== '0 || wb_if.wishbone_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got drive %h data %h required all 0", drv_vec, wb_if.wishbone_data_out);
    end
    @(negedge clk);
    rst = 1'b1;
    wb_read(32'h210, 32'h0000_0000, "reset_status");

    // 2: SET r1 c5 then HALT
    wb_write(32'h000, 32'h2150_0000);
    wb_write(32'h004, 32'hE000_0000);
    repeat (4) exp_cyc(1, 1, 1, 0, 0, 0, 0, 2'b00, 16'h0, 16'h0, 16'h0020, 16'h0002, 16'h0020, 16'h0);
    run_to_done();
    wb_read(32'h210, 32'h0000_0101, "set_status_halted");
    enable_IM = 1'b0;
    wb_read(32'h210, 32'h0000_0000, "set_status_stopped");
    wb_read(32'h000, 32'h2150_0000, "im0_readback");

    // 3: READ r1 c5
    CSA = 16'h0020;
    wb_write(32'h000, 32'h6150_0000);
    exp_cyc(1, 0, 0, 0, 0, 1, 0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0, 16'h0);
    exp_cyc(1, 0, 0, 1, 1, 0, 0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0, 16'h0);
    exp_cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0, 16'h0);
    run_to_done();
    enable_IM = 1'b0;
    wb_read(32'h200, 32'h0020_0001, "read_result");

    // 4: MAC vector 0x00FF
    ADC_OUT0 = 16'h1234;
    ADC_OUT1 = 16'h5678;
    ADC_OUT2 = 16'h9ABC;
    wb_write(32'h000, 32'h8000_00FF);
    exp_cyc(1, 0, 0, 0, 0, 0, 1, 2'b01, 16'h0, 16'h0, 16'h0, 16'h00FF, 16'h0, 16'h0);
    exp_cyc(1, 0, 0, 0, 0, 0, 1, 2'b10, 16'h0, 16'h0, 16'h0, 16'h00FF, 16'h0, 16'h0);
    exp_cyc(1, 0, 0, 0, 0, 0, 1, 2'b00, 16'h0, 16'h0, 16'h0, 16'h00FF, 16'h0, 16'h0);
    run_to_done();
    enable_IM = 1'b0;
    wb_read(32'h204, 32'h0000_1234, "adc0_result");
    wb_read(32'h208, 32'h0000_5678, "adc1_result");
    wb_read(32'h20C, 32'h0000_9ABC, "adc2_result");
    wb_read(32'h200, 32'h0020_0001, "read_result_kept");
    wb_read(32'h214, 32'h0000_0000, "perf_absent");
    wb_read(32'h300, 32'h0000_0000, "unmapped_read");

    // 5: abort mid-SET r3 c2 after two drive cycles
    wb_write(32'h000, 32'h2320_0000);
    repeat (2) exp_cyc(1, 1, 1, 0, 0, 0, 0, 2'b00, 16'h0, 16'h0, 16'h0004, 16'h0008, 16'h0004, 16'h0);
    @(negedge clk);
    enable_IM = 1'b1;
    repeat (3) @(negedge clk);
    enable_IM = 1'b0;
    @(negedge clk);
    n_checks++;
    if (drv_vec !== '0) begin
      n_fail++;
      $display("FAIL abort_drivers: got %h required 0", drv_vec);
    end
    wb_read(32'h210, 32'h0000_0000, "abort_status");
    wb_write(32'h014, 32'h1234_5678);
    wb_read(32'h014, 32'h1234_5678, "im_write_after_abort");

    // 6: NOP, RESET r1 c5, HALT; IM write while running is dropped
    wb_write(32'h000, 32'h0000_0000);
    wb_write(32'h004, 32'h4150_0000);
    wb_write(32'h008, 32'hE000_0000);
    repeat (4) exp_cyc(1, 1, 1, 0, 0, 0, 0, 2'b00, 16'h0, 16'h0020, 16'h0, 16'h0002, 16'h0, 16'h0020);
    run_to_done();
    wb_write(32'h008, 32'hDEAD_BEEF);
    wb_read(32'h210, 32'h0000_0102, "reset_prog_status");
    enable_IM = 1'b0;
    wb_read(32'h008, 32'hE000_0000, "im_write_ignored");

    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_drv_q.size() != 0) begin
      n_fail++;
      $display("FAIL drive_queue_drained: got %0d left required 0", exp_drv_q.size());
    end
    n_checks++;
    if (exp_rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_queue_drained: got %0d left required 0", exp_rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
